// File: rtl/serial_add_ctrl.sv
// Sequencer for a bit-serial adder: accepts an operand pair, runs WIDTH LSB-first
// full-adder steps, then holds sum/carry/overflow until the consumer takes it.
module serial_add_ctrl #(
   parameter int  WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
   logic               c_q, c_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_sum_q, out_sum_d;
   logic               out_cout_q, out_cout_d;
   logic               out_ovf_q, out_ovf_d;
   logic               busy_q, busy_d;

   logic [WIDTH-1:0]   b_prime;
   logic               s_bit;
   logic               carry;
   logic [WIDTH-1:0]   sum_next;

   // Subtract is A + ~B + 1, so B is inverted at load and the carry seeded to 1.
   assign b_prime  = in_sub ? ~in_b : in_b;
   assign s_bit    = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
   assign carry    = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
   assign sum_next = {s_bit, sum_sr_q[WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      a_sr_d      = a_sr_q;
      b_sr_d      = b_sr_q;
      sum_sr_d    = sum_sr_q;
      c_d         = c_q;
      cnt_d       = cnt_q;
      a_msb_d     = a_msb_q;
      b_msb_d     = b_msb_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_cout_d  = out_cout_q;
      out_ovf_d   = out_ovf_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sr_d     = in_a;
               b_sr_d     = b_prime;
               c_d        = in_sub | in_cin;
               cnt_d      = '0;
               a_msb_d    = in_a[WIDTH-1];
               b_msb_d    = b_prime[WIDTH-1];
               sum_sr_d   = '0;
               state_d    = SHIFT;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         SHIFT: begin
            sum_sr_d = sum_next;
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            c_d      = carry;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d     = DONE;
               busy_d      = 1'b0;
               out_valid_d = 1'b1;
               out_sum_d   = sum_next;
               out_cout_d  = carry;
               // s_bit is the final sum MSB on the last step.
               out_ovf_d   = (a_msb_q == b_msb_q) & (s_bit != a_msb_q);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
               out_sum_d   = '0;
               out_cout_d  = 1'b0;
               out_ovf_d   = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_sr_q      <= '0;
         b_sr_q      <= '0;
         sum_sr_q    <= '0;
         c_q         <= 1'b0;
         cnt_q       <= '0;
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sr_q      <= a_sr_d;
         b_sr_q      <= b_sr_d;
         sum_sr_q    <= sum_sr_d;
         c_q         <= c_d;
         cnt_q       <= cnt_d;
         a_msb_q     <= a_msb_d;
         b_msb_q     <= b_msb_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_cout_q  <= out_cout_d;
         out_ovf_q   <= out_ovf_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign out_ovf   = out_ovf_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed operand pairs with hand-computed
// results; a negedge monitor checks every output transfer against the queue.
module tb_serial_add_ctrl;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             busy;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Monitor: one comparison per output transfer, independent of the stimulus.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checkOutput("unexpected_result", 1, 0);
         end else begin
            e = sb_q.pop_front();
            checkOutput("out_sum", int'(out_sum), int'(e.sum));
            checkOutput("out_cout", int'(out_cout), int'(e.cout));
            checkOutput("out_ovf", int'(out_ovf), int'(e.ovf));
         end
      end
   end

   task automatic waitInReady();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin, input logic sub,
                                input logic [WIDTH-1:0] e_sum, input logic e_cout,
                                input logic e_ovf, input bit push);
      exp_t e;
      waitInReady();
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_sub   = sub;
      in_valid = 1'b1;
      @(posedge clk);
      if (push) begin
         e.sum  = e_sum;
         e.cout = e_cout;
         e.ovf  = e_ovf;
         sb_q.push_back(e);
      end
      #1;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_cin   = 1'b0;
      in_sub   = 1'b0;
   endtask

   // Called right after applyStimulus; counts cycles to out_valid and busy cycles.
   task automatic waitOutValid(output int cyc, output int busy_cnt);
      cyc      = 0;
      busy_cnt = busy ? 1 : 0;
      while (!out_valid && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
         if (busy) busy_cnt++;
      end
      if (!out_valid) checkOutput("out_valid_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int               lat;
      int               bcnt;
      int               n;
      bit               held;
      logic [WIDTH-1:0] snap;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      in_sub    = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", int'(in_ready), 1);
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_out_sum", int'(out_sum), 0);
      checkOutput("reset_busy", int'(busy), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Add with signed overflow and the WIDTH-cycle latency.
      out_ready = 1'b1;
      applyStimulus(4'd3, 4'd5, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1);
      waitOutValid(lat, bcnt);
      checkOutput("latency_add", lat, WIDTH);
      checkOutput("busy_cycles_add", bcnt, WIDTH);

      // Carry out of the MSB with carry-in; sum wraps.
      applyStimulus(4'd15, 4'd1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1);
      waitOutValid(lat, bcnt);
      checkOutput("busy_cycles_wrap", bcnt, 4);
      checkOutput("in_ready_in_done", int'(in_ready), 0);

      // Subtract: borrow case and signed-overflow case.
      applyStimulus(4'd2, 4'd5, 1'b1, 1'b1, 4'd13, 1'b0, 1'b0, 1'b1);
      waitOutValid(lat, bcnt);
      applyStimulus(4'd8, 4'd1, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1);
      waitOutValid(lat, bcnt);

      // Backpressure: result must hold for 10 cycles without handoff.
      @(posedge clk); #1;
      out_ready = 1'b0;
      applyStimulus(4'd9, 4'd4, 1'b0, 1'b0, 4'd13, 1'b0, 1'b0, 1'b1);
      waitOutValid(lat, bcnt);
      snap = out_sum;
      held = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_sum !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) held = 1'b0;
      end
      checkOutput("backpressure_hold", int'(held), 1);
      checkOutput("backpressure_sum", int'(out_sum), 13);
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("release_in_ready", int'(in_ready), 1);
      checkOutput("release_out_valid", int'(out_valid), 0);

      // Abort in the 2nd SHIFT cycle; the aborted result must never appear.
      applyStimulus(4'd7, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort_in_ready", int'(in_ready), 1);
      checkOutput("abort_out_valid", int'(out_valid), 0);
      checkOutput("abort_out_sum", int'(out_sum), 0);
      checkOutput("abort_out_cout", int'(out_cout), 0);
      checkOutput("abort_out_ovf", int'(out_ovf), 0);
      checkOutput("abort_busy", int'(busy), 0);
      rst  = 1'b0;
      held = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || busy !== 1'b0) held = 1'b0;
      end
      checkOutput("abort_stays_idle", int'(held), 1);
      applyStimulus(4'd6, 4'd6, 1'b0, 1'b0, 4'd12, 1'b0, 1'b1, 1'b1);
      waitOutValid(lat, bcnt);
      checkOutput("latency_after_abort", lat, WIDTH);

      // Junk in_valid during SHIFT/DONE, including the handoff cycle.
      @(posedge clk); #1;
      out_ready = 1'b0;
      applyStimulus(4'd5, 4'd2, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         in_valid = ~in_valid;
         in_a     = 4'hA;
         in_b     = 4'h7;
         in_cin   = 1'b1;
         in_sub   = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n++;
      end
      checkOutput("ignore_out_valid", int'(out_valid), 1);
      in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("ignore_handoff_idle", int'(in_ready), 1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      checkOutput("ignore_no_extra_accept", int'(busy), 0);
      checkOutput("ignore_still_ready", int'(in_ready), 1);

      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("scoreboard_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
